// File: rtl/ram_nb_8w_pkg.sv
// ram_nb_8w_pkg: shared constants and types for the eight-word byte-sliced RAM.
//   RAM_WORDS  number of words in every lane
//   RAM_AW     word address width
//   BYTE_W     width of one byte lane
//   ram_addr_t word address type
package ram_nb_8w_pkg;
    localparam int RAM_WORDS = 8;
    localparam int RAM_AW    = 3;
    localparam int BYTE_W    = 8;

    typedef logic [RAM_AW-1:0] ram_addr_t;
endpackage

// File: rtl/ram_8b8w_slice.sv
// ram_8b8w_slice: one 8-bit x 8-word byte lane.
// The lane holds the synchronous clear, the synchronous write and the combinational read.
// Ports:
//   clk    clock; all state changes happen on its rising edge
//   rst_n  synchronous active-low clear of all words
//   A      word address
//   din    write byte
//   WR     write strobe, active low
//   dout   stored byte at A (combinational)
module ram_8b8w_slice
    import ram_nb_8w_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  ram_addr_t         A,
    input  logic [BYTE_W-1:0] din,
    input  logic              WR,
    output logic [BYTE_W-1:0] dout
);

    logic [RAM_WORDS-1:0][BYTE_W-1:0] mem_q;

    // Clear wins over a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (!WR) begin
            mem_q[A] <= din;
        end
    end

    assign dout = mem_q[A];

endmodule

// File: rtl/ram_nb_8w.sv
// ram_nb_8w: eight-word RAM, NBYTES bytes per word, built from NBYTES byte-lane slices
// that share one address. Synchronous write, combinational read, synchronous clear.
// Optional build macro: RAM_NB_8W_BYPASS_EN -- when defined, a write in progress
// (WR=0, rst_n=1) is forwarded from DIN to DOUT before the clock edge.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low clear of every word
//   A      word address 0..7
//   DIN    write data, W = 8*NBYTES bits
//   OE     output enable, active high; 0 forces DOUT to zero
//   WR     write strobe, active low
//   DOUT   read data (never tri-stated)
module ram_nb_8w
    import ram_nb_8w_pkg::*;
#(
    parameter int NBYTES = 32,
    localparam int W     = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  ram_addr_t    A,
    input  logic [W-1:0] DIN,
    input  logic         OE,
    input  logic         WR,
    output logic [W-1:0] DOUT
);

    logic [NBYTES-1:0][BYTE_W-1:0] din_lane;
    logic [NBYTES-1:0][BYTE_W-1:0] dout_lane;
    logic [W-1:0]                  rd_word;

    assign din_lane = DIN;

    for (genvar k = 0; k < NBYTES; k++) begin : g_lane
        ram_8b8w_slice u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .A     (A),
            .din   (din_lane[k]),
            .WR    (WR),
            .dout  (dout_lane[k])
        );
    end

`ifdef RAM_NB_8W_BYPASS_EN
    // Forward the word being written; read and write share A so only that word is visible.
    always_comb begin
        rd_word = dout_lane;
        if (!WR && rst_n) begin
            rd_word = DIN;
        end
    end
`else
    assign rd_word = dout_lane;
`endif

    assign DOUT = OE ? rd_word : '0;

endmodule

// File: tb/tb_ram_nb_8w.sv
// tb_ram_nb_8w: directed self-checking bench for ram_nb_8w (NBYTES=32, 256-bit words).
module tb_ram_nb_8w;
    import ram_nb_8w_pkg::*;

    localparam int NB = 32;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    ram_addr_t    A;
    logic [W-1:0] DIN;
    logic         OE;
    logic         WR;
    logic [W-1:0] DOUT;

    int checks   = 0;
    int failures = 0;

    ram_nb_8w #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .DIN   (DIN),
        .OE    (OE),
        .WR    (WR),
        .DOUT  (DOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input ram_addr_t a, input logic [W-1:0] d);
        A   = a;
        DIN = d;
        WR  = 1'b0;
        tick();
        WR  = 1'b1;
    endtask

    initial begin : stim
        logic [7:0]   b;
        logic [W-1:0] exp;
        logic [W-1:0] aa;
        logic [W-1:0] f55;

        rst_n = 1'b1;
        A     = '0;
        DIN   = '0;
        OE    = 1'b1;
        WR    = 1'b1;
        #1;

        // Random writes, then a one-cycle clear.
        for (int i = 0; i < 8; i++) begin
            wr_word(ram_addr_t'(i), {8{$urandom}});
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            A = ram_addr_t'(i);
            #1;
            check($sformatf("reset_a%0d", i), DOUT, '0);
        end

        // Fill all words, then sweep A with no clock between reads.
        for (int i = 0; i < 8; i++) begin
            b = 8'(i * 17 + 3);
            wr_word(ram_addr_t'(i), {NB{b}});
        end
        for (int i = 0; i < 8; i++) begin
            A = ram_addr_t'(i);
            #1;
            b = 8'(i * 17 + 3);
            check($sformatf("fill_a%0d", i), DOUT, {NB{b}});
        end

        // OE gating.
        OE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            A = ram_addr_t'(i);
            #1;
            check($sformatf("oe0_a%0d", i), DOUT, '0);
        end
        A  = 3'd3;
        OE = 1'b1;
        #1;
        check("oe1_a3", DOUT, {NB{8'd54}});

        // Back-to-back writes to one address: last wins.
        wr_word(3'd1, {NB{8'h3C}});
        wr_word(3'd1, {NB{8'hC3}});
        A = 3'd1;
        #1;
        check("b2b_last_wins", DOUT, {NB{8'hC3}});

        // Reset priority over a same-cycle write.
        A     = 3'd5;
        DIN   = '1;
        WR    = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        WR    = 1'b1;
        #1;
        check("rst_prio_a5", DOUT, '0);
        A = 3'd1;
        #1;
        check("rst_clears_a1", DOUT, '0);

        // Read during write at A=2.
        aa  = {NB{8'hAA}};
        f55 = {NB{8'h55}};
        wr_word(3'd2, aa);
        A   = 3'd2;
        DIN = f55;
        WR  = 1'b0;
        #1;
`ifdef RAM_NB_8W_BYPASS_EN
        check("rdw_before_edge", DOUT, f55);
`else
        check("rdw_before_edge", DOUT, aa);
`endif
        tick();
        WR = 1'b1;
        #1;
        check("rdw_after_edge", DOUT, f55);

        // Lane independence: only the top byte of A=7 gets 0xFF.
        wr_word(3'd6, {NB{8'h12}});
        exp = '0;
        exp[W-1 -: 8] = 8'hFF;
        wr_word(3'd7, exp);
        A = 3'd7;
        #1;
        check("lane_a7", DOUT, exp);
        A = 3'd6;
        #1;
        check("lane_a6_untouched", DOUT, {NB{8'h12}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
